branch_resolve_queue: RTL and testbench

In-order tracker for predicted branches between fetch and the predictor's feedback port. Fetch allocates one entry per prediction it consumes (pc, pred_taken, exec_alt). Execute resolves entries out of order by tag. The queue retires entries in program order, drives core::branch_pred_fb_t back into the predictor, and raises a flush on a true mispredict, meaning a mispredict that no alternate path covered.

---
 rtl/core.sv | 21 ++
 rtl/branch_resolve_queue.sv | 123 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core.sv
// Shared core types: predictor feedback bundle and the branch resolve queue entry.
package core;

  localparam int PC_WIDTH = 32;

  typedef struct packed {
    logic                valid;
    logic [PC_WIDTH-1:0] base_pc;
    logic                branch_taken;
  } branch_pred_fb_t;

  typedef struct packed {
    logic                valid;
    logic                resolved;
    logic [PC_WIDTH-1:0] pc;
    logic                pred_taken;
    logic                exec_alt;
    logic                taken;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue.sv
// In-order branch tracker: allocated by fetch, resolved out of order by execute,
// retired in program order with predictor feedback and flush on a true mispredict.
module branch_resolve_queue
  import core::*;
#(
  parameter int depth    = 8,
  parameter int pc_width = core::PC_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          alloc_valid,
  input  logic [pc_width-1:0]           alloc_pc,
  input  logic                          alloc_pred_taken,
  input  logic                          alloc_exec_alt,
  output logic                          alloc_ready,
  output logic [$clog2(depth)-1:0]      alloc_tag,
  input  logic                          res_valid,
  input  logic [$clog2(depth)-1:0]      res_tag,
  input  logic                          res_taken,
  output core::branch_pred_fb_t         branch_pred_fb,
  output logic                          flush,
  output logic [pc_width-1:0]           flush_pc,
  output logic [$clog2(depth):0]        count
);

  localparam int IDX = $clog2(depth);

  typedef logic [IDX-1:0] tag_t;
  typedef logic [IDX:0]   ptr_t;

  brq_entry_t      entries_q [depth];
  brq_entry_t      entries_d [depth];
  ptr_t            head_q, head_d, tail_q, tail_d;
  branch_pred_fb_t fb_q, fb_d;
  logic            flush_q, flush_d;
  logic [pc_width-1:0] flush_pc_q, flush_pc_d;

  brq_entry_t headEntry;
  tag_t       headIdx, tailIdx;
  logic       full, retire, flushNow;

  assign headIdx = head_q[IDX-1:0];
  assign tailIdx = tail_q[IDX-1:0];

  // Retire and flush are decided purely from registered state, so a resolve never bypasses to retire.
  always_comb begin
    headEntry   = entries_q[headIdx];
    full        = (head_q[IDX] != tail_q[IDX]) && (headIdx == tailIdx);
    retire      = en && headEntry.valid && headEntry.resolved;
    flushNow    = retire && (headEntry.taken != headEntry.pred_taken) && !headEntry.exec_alt;
    alloc_ready = rst && en && !full && !flushNow;
    alloc_tag   = tailIdx;
    count       = tail_q - head_q;
  end

  always_comb begin
    entries_d        = entries_q;
    head_d           = head_q;
    tail_d           = tail_q;
    fb_d             = fb_q;
    fb_d.valid       = 1'b0;
    flush_d          = 1'b0;
    flush_pc_d       = flush_pc_q;

    if (en && res_valid && entries_q[res_tag].valid && !entries_q[res_tag].resolved) begin
      entries_d[res_tag].resolved = 1'b1;
      entries_d[res_tag].taken    = res_taken;
    end

    if (alloc_valid && alloc_ready) begin
      entries_d[tailIdx].valid      = 1'b1;
      entries_d[tailIdx].resolved   = 1'b0;
      entries_d[tailIdx].pc         = alloc_pc;
      entries_d[tailIdx].pred_taken = alloc_pred_taken;
      entries_d[tailIdx].exec_alt   = alloc_exec_alt;
      entries_d[tailIdx].taken      = 1'b0;
      tail_d                        = tail_q + ptr_t'(1);
    end

    if (retire) begin
      entries_d[headIdx].valid = 1'b0;
      head_d                   = head_q + ptr_t'(1);
      fb_d.valid               = 1'b1;
      fb_d.base_pc             = headEntry.pc;
      fb_d.branch_taken        = headEntry.taken;
      // A true mispredict squashes every younger entry by collapsing tail onto the new head.
      if (flushNow) begin
        for (int i = 0; i < depth; i++) begin
          entries_d[i].valid = 1'b0;
        end
        tail_d     = head_q + ptr_t'(1);
        flush_d    = 1'b1;
        flush_pc_d = headEntry.pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < depth; i++) begin
        entries_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      fb_q       <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      entries_q  <= entries_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fb_q       <= fb_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  assign branch_pred_fb = fb_q;
  assign flush          = flush_q;
  assign flush_pc       = flush_pc_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios plus a
// randomized run against a program-order queue model.
module tb_branch_resolve_queue;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic                  alloc_valid;
  logic [31:0]           alloc_pc;
  logic                  alloc_pred_taken;
  logic                  alloc_exec_alt;
  logic                  alloc_ready;
  logic [2:0]            alloc_tag;
  logic                  res_valid;
  logic [2:0]            res_tag;
  logic                  res_taken;
  core::branch_pred_fb_t fb;
  logic                  flush;
  logic [31:0]           flush_pc;
  logic [3:0]            count;

  int checks   = 0;
  int failures = 0;

  branch_resolve_queue #(.depth(8), .pc_width(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .alloc_valid      (alloc_valid),
    .alloc_pc         (alloc_pc),
    .alloc_pred_taken (alloc_pred_taken),
    .alloc_exec_alt   (alloc_exec_alt),
    .alloc_ready      (alloc_ready),
    .alloc_tag        (alloc_tag),
    .res_valid        (res_valid),
    .res_tag          (res_tag),
    .res_taken        (res_taken),
    .branch_pred_fb   (fb),
    .flush            (flush),
    .flush_pc         (flush_pc),
    .count            (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic e, input logic av, input logic [31:0] pc,
                               input logic pt, input logic alt, input logic rv,
                               input logic [2:0] rt, input logic rtk);
    en = e; alloc_valid = av; alloc_pc = pc; alloc_pred_taken = pt;
    alloc_exec_alt = alt; res_valid = rv; res_tag = rt; res_taken = rtk;
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  // Advance past the next rising edge so registered outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic doReset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    idle();
    alloc_valid = 1'b1;
    rst = 1'b0;
    tick();
    checks++; if (alloc_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got %0b want 0", alloc_ready); end
    checks++; if (count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    checks++; if (fb !== '0) begin failures++; $display("[TB] FAIL reset_fb got %h want 0", fb); end
    checks++; if (flush !== 1'b0 || flush_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_flush got %0b/%h want 0/0", flush, flush_pc); end
    rst = 1'b1;
    idle();
    settle();
  endtask

  task automatic test_basic();
    doReset();
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    settle();
    checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin failures++; $display("[TB] FAIL basic_alloc got rdy=%0b tag=%0d want 1/0", alloc_ready, alloc_tag); end
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
    settle();
    checks++; if (count !== 4'd1) begin failures++; $display("[TB] FAIL basic_count1 got %0d want 1", count); end
    tick();
    idle();
    tick();
    checks++; if (fb.valid !== 1'b1 || fb.base_pc !== 32'h100 || fb.branch_taken !== 1'b1) begin failures++; $display("[TB] FAIL basic_fb got v=%0b pc=%h t=%0b want 1/100/1", fb.valid, fb.base_pc, fb.branch_taken); end
    checks++; if (flush !== 1'b0 || count !== 4'd0) begin failures++; $display("[TB] FAIL basic_post got flush=%0b count=%0d want 0/0", flush, count); end
    tick();
    checks++; if (fb.valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_pulse got %0b want 0", fb.valid); end
  endtask

  task automatic test_in_order();
    logic [2:0] order [3];
    order[0] = 3'd2; order[1] = 3'd1; order[2] = 3'd0;
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h10 * (i + 1), 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      settle();
      checks++; if (alloc_tag !== 3'(i)) begin failures++; $display("[TB] FAIL order_tag got %0d want %0d", alloc_tag, i); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, order[i], 1'b0);
      tick();
      checks++; if (fb.valid !== 1'b0) begin failures++; $display("[TB] FAIL order_early got %0b want 0", fb.valid); end
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (fb.valid !== 1'b1 || fb.base_pc !== 32'h10 * (i + 1) || fb.branch_taken !== 1'b0) begin failures++; $display("[TB] FAIL order_fb got v=%0b pc=%h t=%0b want 1/%h/0", fb.valid, fb.base_pc, fb.branch_taken, 32'h10 * (i + 1)); end
    end
    tick();
    checks++; if (fb.valid !== 1'b0 || count !== 4'd0) begin failures++; $display("[TB] FAIL order_end got v=%0b count=%0d want 0/0", fb.valid, count); end
  endtask

  task automatic test_mispredict(input logic alt);
    doReset();
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, alt, 1'b0, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
    tick();
    applyStimulus(1'b1, !alt, 32'h99, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    settle();
    checks++; if (alloc_ready !== alt) begin failures++; $display("[TB] FAIL misp_ready alt=%0b got %0b want %0b", alt, alloc_ready, alt); end
    tick();
    checks++; if (fb.valid !== 1'b1 || fb.base_pc !== 32'h40 || fb.branch_taken !== 1'b1) begin failures++; $display("[TB] FAIL misp_fb alt=%0b got v=%0b pc=%h t=%0b want 1/40/1", alt, fb.valid, fb.base_pc, fb.branch_taken); end
    checks++; if (flush !== !alt || flush_pc !== (alt ? 32'h0 : 32'h40)) begin failures++; $display("[TB] FAIL misp_flush alt=%0b got %0b/%h want %0b/%h", alt, flush, flush_pc, !alt, alt ? 32'h0 : 32'h40); end
    checks++; if (count !== (alt ? 4'd1 : 4'd0)) begin failures++; $display("[TB] FAIL misp_count alt=%0b got %0d want %0d", alt, count, alt ? 1 : 0); end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    tick();
    idle();
    tick();
    checks++; if (fb.valid !== alt || flush !== 1'b0) begin failures++; $display("[TB] FAIL misp_younger alt=%0b got v=%0b flush=%0b want %0b/0", alt, fb.valid, flush, alt); end
    if (alt) begin
      checks++; if (fb.base_pc !== 32'h44) begin failures++; $display("[TB] FAIL misp_younger_pc got %h want 44", fb.base_pc); end
    end
    checks++; if (count !== 4'd0 || alloc_tag !== (alt ? 3'd2 : 3'd1)) begin failures++; $display("[TB] FAIL misp_ptrs alt=%0b got count=%0d tag=%0d want 0/%0d", alt, count, alloc_tag, alt ? 2 : 1); end
  endtask

  task automatic test_full();
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    settle();
    checks++; if (alloc_ready !== 1'b0 || count !== 4'd8) begin failures++; $display("[TB] FAIL full_state got rdy=%0b count=%0d want 0/8", alloc_ready, count); end
    tick();
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    settle();
    checks++; if (alloc_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_nobypass got %0b want 0", alloc_ready); end
    tick();
    checks++; if (count !== 4'd7 || fb.valid !== 1'b1 || fb.base_pc !== 32'h200) begin failures++; $display("[TB] FAIL full_retire got count=%0d v=%0b pc=%h want 7/1/200", count, fb.valid, fb.base_pc); end
    checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin failures++; $display("[TB] FAIL full_wrap got rdy=%0b tag=%0d want 1/0", alloc_ready, alloc_tag); end
    tick();
    checks++; if (count !== 4'd8) begin failures++; $display("[TB] FAIL full_refill got %0d want 8", count); end
    idle();
  endtask

  task automatic test_enable_and_reset();
    doReset();
    applyStimulus(1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
    tick();
    idle();
    tick();
    tick();
    checks++; if (fb.valid !== 1'b0 || count !== 4'd1) begin failures++; $display("[TB] FAIL en_drop got v=%0b count=%0d want 0/1", fb.valid, count); end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    checks++; if (fb.valid !== 1'b0 || count !== 4'd1) begin failures++; $display("[TB] FAIL en_freeze got v=%0b count=%0d want 0/1", fb.valid, count); end
    idle();
    tick();
    checks++; if (fb.valid !== 1'b1 || fb.base_pc !== 32'h500 || count !== 4'd0) begin failures++; $display("[TB] FAIL en_resume got v=%0b pc=%h count=%0d want 1/500/0", fb.valid, fb.base_pc, count); end
    applyStimulus(1'b1, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h604, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    tick();
    idle();
    tick();
    checks++; if (fb.valid !== 1'b1 || count !== 4'd1) begin failures++; $display("[TB] FAIL midrst_pre got v=%0b count=%0d want 1/1", fb.valid, count); end
    rst = 1'b0;
    settle();
    checks++; if (fb.valid !== 1'b0 || count !== 4'd0 || flush !== 1'b0 || alloc_ready !== 1'b0) begin failures++; $display("[TB] FAIL midrst got v=%0b count=%0d flush=%0b rdy=%0b want 0/0/0/0", fb.valid, count, flush, alloc_ready); end
    tick();
    rst = 1'b1;
    settle();
  endtask

  // Program-order reference: the queue front is the oldest branch, tags are handed out modulo 8.
  typedef struct {
    logic [2:0]  tag;
    logic [31:0] pc;
    logic        pred;
    logic        alt;
    logic        resolved;
    logic        taken;
  } mEnt;

  task automatic test_random();
    mEnt         mq[$];
    int          nextTag = 0;
    logic [31:0] lastPc = 32'h0;
    logic [31:0] lastFlushPc = 32'h0;
    logic        lastTaken = 1'b0;
    logic        e, av, pt, alt, rv, rtk, retire, fnow, expReady, expFb, expFlush;
    logic [2:0]  rt;
    logic [31:0] pc;
    doReset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      e   = ($urandom_range(0, 9) != 0);
      av  = ($urandom_range(0, 2) != 0);
      pc  = $urandom;
      pt  = 1'($urandom_range(0, 1));
      alt = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 4) < 3);
      rtk = 1'($urandom_range(0, 1));
      rt  = 3'($urandom_range(0, 7));
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        int k = $urandom_range(0, mq.size() - 1);
        rt  = mq[k].tag;
        rtk = mq[k].pred ^ ($urandom_range(0, 4) == 0);
      end
      retire   = e && mq.size() > 0 && mq[0].resolved;
      fnow     = retire && (mq[0].taken != mq[0].pred) && !mq[0].alt;
      expReady = e && mq.size() < 8 && !fnow;
      applyStimulus(e, av, pc, pt, alt, rv, rt, rtk);
      settle();
      checks++; if (alloc_ready !== expReady) begin failures++; $display("[TB] FAIL rnd_ready cyc=%0d got %0b want %0b", cyc, alloc_ready, expReady); end
      checks++; if (alloc_tag !== 3'(nextTag)) begin failures++; $display("[TB] FAIL rnd_tag cyc=%0d got %0d want %0d", cyc, alloc_tag, nextTag); end
      checks++; if (count !== 4'(mq.size())) begin failures++; $display("[TB] FAIL rnd_count cyc=%0d got %0d want %0d", cyc, count, mq.size()); end
      tick();
      if (e && rv) begin
        foreach (mq[j]) begin
          if (mq[j].tag == rt && !mq[j].resolved) begin
            mq[j].resolved = 1'b1;
            mq[j].taken    = rtk;
          end
        end
      end
      expFb    = retire;
      expFlush = fnow;
      if (retire) begin
        lastPc    = mq[0].pc;
        lastTaken = mq[0].taken;
        nextTag   = fnow ? (mq[0].tag + 1) % 8 : nextTag;
        if (fnow) lastFlushPc = mq[0].pc;
        void'(mq.pop_front());
        if (fnow) mq.delete();
      end
      if (av && expReady) begin
        mq.push_back('{tag: 3'(nextTag), pc: pc, pred: pt, alt: alt, resolved: 1'b0, taken: 1'b0});
        nextTag = (nextTag + 1) % 8;
      end
      checks++; if (fb.valid !== expFb || fb.base_pc !== lastPc) begin failures++; $display("[TB] FAIL rnd_fb cyc=%0d got v=%0b pc=%h want %0b/%h", cyc, fb.valid, fb.base_pc, expFb, lastPc); end
      if (expFb) begin
        checks++; if (fb.branch_taken !== lastTaken) begin failures++; $display("[TB] FAIL rnd_taken cyc=%0d got %0b want %0b", cyc, fb.branch_taken, lastTaken); end
      end
      checks++; if (flush !== expFlush || flush_pc !== lastFlushPc) begin failures++; $display("[TB] FAIL rnd_flush cyc=%0d got %0b/%h want %0b/%h", cyc, flush, flush_pc, expFlush, lastFlushPc); end
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_in_order();
    test_mispredict(1'b0);
    test_mispredict(1'b1);
    test_full();
    test_enable_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
